// File: rtl/adc_packetizer.sv
// adc_packetizer: buffers ADC sample words in a FIFO and emits {header, PKT_LEN payload} packets.
// Define ADC_PKT_TIMESTAMP_EN to add a popped-sample-count word after each header.
module adc_packetizer #(
   parameter int unsigned PKT_LEN = 64,
   parameter int unsigned FIFO_AW = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        s_valid,
   input  logic [31:0] s_data,
   input  logic        m_ready,
   output logic        m_valid,
   output logic [31:0] m_data,
   output logic        m_last,
   input  logic        ovf_clr,
   output logic        overflow
);

   localparam int unsigned        Depth    = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0]   DepthC   = (FIFO_AW + 1)'(Depth);
   localparam logic [FIFO_AW-1:0] PtrOne   = FIFO_AW'(1);
   localparam logic [FIFO_AW:0]   CntOne   = (FIFO_AW + 1)'(1);
   localparam logic [15:0]        PktLen16 = 16'(PKT_LEN);
   localparam logic [16:0]        PktLen17 = 17'(PKT_LEN);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StHdr  = 2'd1;
   localparam logic [1:0] StPay  = 2'd2;
`ifdef ADC_PKT_TIMESTAMP_EN
   localparam logic [1:0] StTs   = 2'd3;
`endif

   // ---------------------------------------------------------------- sample FIFO
   logic [31:0]        mem_q [Depth];
   logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [FIFO_AW:0]   count_q, count_d;
   logic               fifo_full, fifo_nempty;
   logic               push, pop;

   assign fifo_full   = (count_q == DepthC);
   assign fifo_nempty = (count_q != '0);
   // Fullness is judged before the edge, so a same-cycle pop never rescues a push.
   assign push        = s_valid && !fifo_full;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PtrOne;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrOne;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CntOne;
         2'b01:   count_d = count_q - CntOne;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= s_data;
      end
   end

   // ---------------------------------------------------------------- packet FSM
   logic [1:0]  state_q, state_d;
   logic [15:0] wcnt_q, wcnt_d;
   logic [7:0]  seq_q, seq_d;
   logic        m_valid_q, m_valid_d;
   logic [31:0] m_data_q, m_data_d;
   logic        m_last_q, m_last_d;
   logic        ovf_q, ovf_d;
   logic        xfer, out_en;
   logic        load_hdr, load_pay;
   logic [16:0] pay_idx;
   logic [31:0] hdr_word;
`ifdef ADC_PKT_TIMESTAMP_EN
   logic        load_ts;
   logic [31:0] ts_cnt_q, ts_cnt_d;
`endif

   assign xfer     = m_valid_q && m_ready;
   assign out_en   = !m_valid_q || m_ready;
   assign hdr_word = {8'hA5, seq_q, PktLen16};

   always_comb begin
      state_d  = state_q;
      wcnt_d   = wcnt_q;
      seq_d    = seq_q;
      load_hdr = 1'b0;
      load_pay = 1'b0;
`ifdef ADC_PKT_TIMESTAMP_EN
      load_ts  = 1'b0;
`endif
      case (state_q)
         StIdle: begin
            if (fifo_nempty) begin
               load_hdr = 1'b1;
               state_d  = StHdr;
            end
         end
         StHdr: begin
            if (xfer) begin
               seq_d = seq_q + 8'd1;
`ifdef ADC_PKT_TIMESTAMP_EN
               load_ts = 1'b1;
               state_d = StTs;
`else
               state_d  = StPay;
               wcnt_d   = '0;
               load_pay = fifo_nempty;
`endif
            end
         end
`ifdef ADC_PKT_TIMESTAMP_EN
         StTs: begin
            if (xfer) begin
               state_d  = StPay;
               wcnt_d   = '0;
               load_pay = fifo_nempty;
            end
         end
`endif
         StPay: begin
            if (xfer && m_last_q) begin
               // Chain straight into the next header to keep one word per cycle.
               wcnt_d = '0;
               if (fifo_nempty) begin
                  load_hdr = 1'b1;
                  state_d  = StHdr;
               end else begin
                  state_d = StIdle;
               end
            end else if (out_en) begin
               if (xfer) begin
                  wcnt_d = wcnt_q + 16'd1;
               end
               load_pay = fifo_nempty;
            end
         end
         default: state_d = StIdle;
      endcase

      // wcnt counts transferred payload words, so the word being loaded is wcnt_d + 1.
      pay_idx   = {1'b0, wcnt_d} + 17'd1;
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      m_last_d  = m_last_q;
      pop       = 1'b0;
      if (load_hdr) begin
         m_valid_d = 1'b1;
         m_data_d  = hdr_word;
         m_last_d  = 1'b0;
`ifdef ADC_PKT_TIMESTAMP_EN
      end else if (load_ts) begin
         m_valid_d = 1'b1;
         m_data_d  = ts_cnt_q;
         m_last_d  = 1'b0;
`endif
      end else if (load_pay) begin
         m_valid_d = 1'b1;
         m_data_d  = mem_q[rd_ptr_q];
         m_last_d  = (pay_idx == PktLen17);
         pop       = 1'b1;
      end else if (out_en) begin
         m_valid_d = 1'b0;
         m_last_d  = 1'b0;
      end
   end

   always_comb begin
      ovf_d = ovf_q;
      if (s_valid && fifo_full) begin
         ovf_d = 1'b1;
      end else if (ovf_clr) begin
         ovf_d = 1'b0;
      end
   end

`ifdef ADC_PKT_TIMESTAMP_EN
   always_comb begin
      ts_cnt_d = ts_cnt_q;
      if (pop) begin
         ts_cnt_d = ts_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ts_cnt_q <= '0;
      end else begin
         ts_cnt_q <= ts_cnt_d;
      end
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         state_q   <= StIdle;
         wcnt_q    <= '0;
         seq_q     <= '0;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         m_last_q  <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         state_q   <= state_d;
         wcnt_q    <= wcnt_d;
         seq_q     <= seq_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         m_last_q  <= m_last_d;
         ovf_q     <= ovf_d;
      end
   end

   assign m_valid  = m_valid_q;
   assign m_data   = m_data_q;
   assign m_last   = m_last_q;
   assign overflow = ovf_q;

endmodule
